// File: rtl/processor.sv
// processor -- two-cycle (FETCH/EXEC) 32-bit processor core.
//
// Ports:
//   clk         sole clock, all state changes on its rising edge
//   reset       synchronous active-low reset
//   instruction 32-bit instruction word, sampled in FETCH
//   addr        registered PC; holds the store address during a ST EXEC cycle
//   out         registered data output (result, or store data during ST EXEC)
//   rw          registered bus direction, 1 only during a ST EXEC cycle
//   sys_dne     registered halt flag
//
// Hierarchy: register cells r0..r31 (storage "internal"), controller c.

// One 32-bit register-file cell. No reset: contents survive processor reset.
module register32 (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] internal;

  always_ff @(posedge clk) begin
    if (we) internal <= d;
  end

  assign q = internal;
endmodule

// FETCH/EXEC/HALT sequencer. The opcode comes from the latched IR.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic [1:0] state_q
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;
  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = EXEC;
      EXEC:    state_next = (opcode == 6'h3F) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign state_q = state;
endmodule

module processor (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] addr,
  output logic [31:0] out,
  output logic        rw,
  output logic        sys_dne
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LI    = 6'h0A;
  localparam logic [5:0] OP_ADDI  = 6'h0C;
  localparam logic [5:0] OP_ST    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;

  logic [31:0] ir_reg, pc_reg, addr_reg, out_reg;
  logic        rw_reg, dne_reg;
  logic [1:0]  state;

  logic [31:0] cur, sext, ra_val, rb_val, result;
  logic [5:0]  opcode;
  logic [4:0]  rd, ra_sel, rb_sel;
  logic        wb_en;
  logic [31:0] we;
  logic [31:0] rf_q [32];

  controller c (.clk(clk), .reset(reset), .opcode(ir_reg[31:26]), .state_q(state));

  // In FETCH the live instruction is decoded so a store can set up its bus
  // cycle on the FETCH edge; in EXEC/HALT the latched IR is decoded.
  assign cur    = (state == S_FETCH) ? instruction : ir_reg;
  assign opcode = cur[31:26];
  assign rd     = cur[25:21];
  assign sext   = {{16{cur[15]}}, cur[15:0]};
  assign ra_sel = cur[20:16];
  // Port B reads rd for a store (data to drive on out), rt otherwise.
  assign rb_sel = (opcode == OP_ST) ? rd : cur[15:11];
  assign ra_val = rf_q[ra_sel];
  assign rb_val = rf_q[rb_sel];

  always_comb begin
    wb_en  = 1'b0;
    result = 32'd0;
    case (opcode)
      OP_LI:   begin wb_en = 1'b1; result = sext; end
      OP_ADDI: begin wb_en = 1'b1; result = ra_val + sext; end
      OP_RTYPE: begin
        wb_en = 1'b1;
        case (cur[5:0])
          6'h20:   result = ra_val + rb_val;
          6'h22:   result = ra_val - rb_val;
          6'h24:   result = ra_val & rb_val;
          6'h25:   result = ra_val | rb_val;
          6'h26:   result = ra_val ^ rb_val;
          6'h2A:   result = {31'd0, $signed(ra_val) < $signed(rb_val)};
          default: wb_en = 1'b0;
        endcase
      end
      default: wb_en = 1'b0;
    endcase
  end

  // Write-back only on a non-reset EXEC edge.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_we
      assign we[gi] = reset && (state == S_EXEC) && wb_en && (rd == gi[4:0]);
    end
  endgenerate

  register32 r0  (.clk(clk), .we(we[0]),  .d(result), .q(rf_q[0]));
  register32 r1  (.clk(clk), .we(we[1]),  .d(result), .q(rf_q[1]));
  register32 r2  (.clk(clk), .we(we[2]),  .d(result), .q(rf_q[2]));
  register32 r3  (.clk(clk), .we(we[3]),  .d(result), .q(rf_q[3]));
  register32 r4  (.clk(clk), .we(we[4]),  .d(result), .q(rf_q[4]));
  register32 r5  (.clk(clk), .we(we[5]),  .d(result), .q(rf_q[5]));
  register32 r6  (.clk(clk), .we(we[6]),  .d(result), .q(rf_q[6]));
  register32 r7  (.clk(clk), .we(we[7]),  .d(result), .q(rf_q[7]));
  register32 r8  (.clk(clk), .we(we[8]),  .d(result), .q(rf_q[8]));
  register32 r9  (.clk(clk), .we(we[9]),  .d(result), .q(rf_q[9]));
  register32 r10 (.clk(clk), .we(we[10]), .d(result), .q(rf_q[10]));
  register32 r11 (.clk(clk), .we(we[11]), .d(result), .q(rf_q[11]));
  register32 r12 (.clk(clk), .we(we[12]), .d(result), .q(rf_q[12]));
  register32 r13 (.clk(clk), .we(we[13]), .d(result), .q(rf_q[13]));
  register32 r14 (.clk(clk), .we(we[14]), .d(result), .q(rf_q[14]));
  register32 r15 (.clk(clk), .we(we[15]), .d(result), .q(rf_q[15]));
  register32 r16 (.clk(clk), .we(we[16]), .d(result), .q(rf_q[16]));
  register32 r17 (.clk(clk), .we(we[17]), .d(result), .q(rf_q[17]));
  register32 r18 (.clk(clk), .we(we[18]), .d(result), .q(rf_q[18]));
  register32 r19 (.clk(clk), .we(we[19]), .d(result), .q(rf_q[19]));
  register32 r20 (.clk(clk), .we(we[20]), .d(result), .q(rf_q[20]));
  register32 r21 (.clk(clk), .we(we[21]), .d(result), .q(rf_q[21]));
  register32 r22 (.clk(clk), .we(we[22]), .d(result), .q(rf_q[22]));
  register32 r23 (.clk(clk), .we(we[23]), .d(result), .q(rf_q[23]));
  register32 r24 (.clk(clk), .we(we[24]), .d(result), .q(rf_q[24]));
  register32 r25 (.clk(clk), .we(we[25]), .d(result), .q(rf_q[25]));
  register32 r26 (.clk(clk), .we(we[26]), .d(result), .q(rf_q[26]));
  register32 r27 (.clk(clk), .we(we[27]), .d(result), .q(rf_q[27]));
  register32 r28 (.clk(clk), .we(we[28]), .d(result), .q(rf_q[28]));
  register32 r29 (.clk(clk), .we(we[29]), .d(result), .q(rf_q[29]));
  register32 r30 (.clk(clk), .we(we[30]), .d(result), .q(rf_q[30]));
  register32 r31 (.clk(clk), .we(we[31]), .d(result), .q(rf_q[31]));

  // pc_reg is the architectural PC; addr_reg is what the bus sees, which is
  // the PC except for the single EXEC cycle of a store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_reg   <= 32'd0;
      pc_reg   <= 32'd0;
      addr_reg <= 32'd0;
      out_reg  <= 32'd0;
      rw_reg   <= 1'b0;
      dne_reg  <= 1'b0;
    end else if (state == S_FETCH) begin
      ir_reg <= instruction;
      if (opcode == OP_ST) begin
        rw_reg   <= 1'b1;
        out_reg  <= rb_val;
        addr_reg <= ra_val + sext;
      end
    end else if (state == S_EXEC) begin
      rw_reg <= 1'b0;
      if (opcode == OP_HALT) begin
        dne_reg <= 1'b1;
      end else begin
        pc_reg   <= pc_reg + 32'd4;
        addr_reg <= pc_reg + 32'd4;
        if (wb_en) out_reg <= result;
      end
    end
  end

  assign addr    = addr_reg;
  assign out     = out_reg;
  assign rw      = rw_reg;
  assign sys_dne = dne_reg;
endmodule

// File: tb/tb_processor.sv
module tb_processor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] addr, out;
  logic        rw, sys_dne;

  int checks = 0;
  int passed = 0;

  // Reference model: architectural state only.
  logic [31:0] m_reg [32];
  logic [31:0] m_pc, m_out;
  bit          m_halt;

  processor i1 (.clk(clk), .reset(reset), .instruction(instruction),
                .addr(addr), .out(out), .rw(rw), .sys_dne(sys_dne));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int rs,
                                        input logic [15:0] imm);
    return {op, rd[4:0], rs[4:0], imm};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                        input logic [5:0] funct);
    return {6'h00, rd[4:0], rs[4:0], rt[4:0], 5'd0, funct};
  endfunction

  function automatic logic [31:0] get_reg(input int idx);
    case (idx)
      0: return i1.r0.internal;
      1: return i1.r1.internal;
      2: return i1.r2.internal;
      3: return i1.r3.internal;
      4: return i1.r4.internal;
      5: return i1.r5.internal;
      6: return i1.r6.internal;
      7: return i1.r7.internal;
      default: return 32'd0;
    endcase
  endfunction

  // What the instruction means, computed from its fields with plain arithmetic.
  function automatic void apply_model(input logic [31:0] ins);
    int op, rd, rs, rt, fn;
    int signed a, b, imm;
    if (m_halt) return;
    op = int'(ins[31:26]); rd = int'(ins[25:21]); rs = int'(ins[20:16]);
    rt = int'(ins[15:11]); fn = int'(ins[5:0]);
    imm = int'($signed(ins[15:0]));
    a = int'(m_reg[rs]); b = int'(m_reg[rt]);
    if (op == 63) begin m_halt = 1; return; end
    m_pc = m_pc + 4;
    if (op == 10) begin m_reg[rd] = imm; m_out = imm; end
    else if (op == 12) begin m_reg[rd] = a + imm; m_out = a + imm; end
    else if (op == 43) m_out = m_reg[rd];
    else if (op == 0) begin
      int signed r;
      bit ok = 1;
      case (fn)
        32: r = a + b;
        34: r = a - b;
        36: r = a & b;
        37: r = a | b;
        38: r = a ^ b;
        42: r = (a < b) ? 1 : 0;
        default: ok = 0;
      endcase
      if (ok) begin m_reg[rd] = r; m_out = r; end
    end
  endfunction

  task automatic issue(input logic [31:0] ins);
    instruction = ins;
    @(posedge clk); @(posedge clk); #1;
    apply_model(ins);
    $display("instr %08h : addr=%08h out=%08h rw=%0d dne=%0d", ins, addr, out, rw, sys_dne);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_pc = 0; m_out = 0; m_halt = 0;
  endtask

  task automatic test_reset();
    instruction = 32'd0;
    do_reset();
    checks++; if (addr !== 32'd0) $display("FAIL reset_addr got %08h want 0", addr); else passed++;
    checks++; if (out !== 32'd0) $display("FAIL reset_out got %08h want 0", out); else passed++;
    checks++; if (rw !== 1'b0 || sys_dne !== 1'b0)
      $display("FAIL reset_flags got rw=%0d dne=%0d want 0/0", rw, sys_dne); else passed++;
    checks++; if (int'(i1.c.state) != 0) $display("FAIL reset_state got %0d want 0", i1.c.state); else passed++;
  endtask

  task automatic test_li_basic();
    issue(32'h2B40FA37);
    checks++; if (i1.r26.internal !== 32'hFFFFFA37)
      $display("FAIL li_r26 got %08h want FFFFFA37", i1.r26.internal); else passed++;
    checks++; if (addr !== 32'd4) $display("FAIL li_addr got %08h want 4", addr); else passed++;
    checks++; if (out !== 32'hFFFFFA37) $display("FAIL li_out got %08h want FFFFFA37", out); else passed++;
  endtask

  task automatic test_li_sequence();
    issue(32'h2BA0600B);
    checks++; if (int'(i1.c.state) != 0) $display("FAIL seq_state1 got %0d want 0", i1.c.state); else passed++;
    issue(32'h2B800035);
    checks++; if (int'(i1.c.state) != 0) $display("FAIL seq_state2 got %0d want 0", i1.c.state); else passed++;
    issue(32'h2B600183);
    checks++; if (int'(i1.c.state) != 0) $display("FAIL seq_state3 got %0d want 0", i1.c.state); else passed++;
    checks++; if (i1.r29.internal !== 32'h0000600B)
      $display("FAIL seq_r29 got %08h want 0000600B", i1.r29.internal); else passed++;
    checks++; if (i1.r28.internal !== 32'h00000035)
      $display("FAIL seq_r28 got %08h want 00000035", i1.r28.internal); else passed++;
    checks++; if (i1.r27.internal !== 32'h00000183)
      $display("FAIL seq_r27 got %08h want 00000183", i1.r27.internal); else passed++;
    checks++; if (i1.r26.internal !== 32'hFFFFFA37)
      $display("FAIL seq_r26 got %08h want FFFFFA37", i1.r26.internal); else passed++;
    checks++; if (addr !== 32'd16) $display("FAIL seq_addr got %08h want 10", addr); else passed++;
  endtask

  task automatic test_rtype();
    logic [5:0]  fns  [3] = '{6'h20, 6'h22, 6'h2A};
    logic [31:0] want [3] = '{32'd2, 32'd8, 32'd0};
    issue(enc_i(6'h0A, 1, 0, 16'd5));
    issue(enc_i(6'h0A, 2, 0, 16'hFFFD));
    for (int k = 0; k < 3; k++) begin
      issue(enc_r(3, 1, 2, fns[k]));
      checks++; if (i1.r3.internal !== want[k])
        $display("FAIL rtype_r3_%0d got %08h want %08h", k, i1.r3.internal, want[k]); else passed++;
      checks++; if (out !== want[k])
        $display("FAIL rtype_out_%0d got %08h want %08h", k, out, want[k]); else passed++;
    end
  endtask

  task automatic test_store();
    logic [31:0] ins;
    ins = enc_i(6'h2B, 1, 2, 16'd4);
    instruction = ins;
    @(posedge clk); #1;
    checks++; if (rw !== 1'b1) $display("FAIL st_rw got %0d want 1", rw); else passed++;
    checks++; if (out !== 32'd5) $display("FAIL st_out got %08h want 5", out); else passed++;
    checks++; if (addr !== 32'd1) $display("FAIL st_addr got %08h want 1", addr); else passed++;
    @(posedge clk); #1;
    apply_model(ins);
    $display("instr %08h : addr=%08h out=%08h rw=%0d dne=%0d", ins, addr, out, rw, sys_dne);
    checks++; if (rw !== 1'b0) $display("FAIL st_rw_after got %0d want 0", rw); else passed++;
    checks++; if (addr !== m_pc) $display("FAIL st_pc_after got %08h want %08h", addr, m_pc); else passed++;
  endtask

  task automatic test_random();
    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    for (int r = 0; r < 8; r++) issue(enc_i(6'h0A, r, 0, 16'($urandom)));
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      int k, rd, rs, rt, other;
      k = $urandom_range(0, 5);
      rd = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
      case (k)
        0: ins = enc_i(6'h0A, rd, rs, 16'($urandom));
        1: ins = enc_i(6'h0C, rd, rs, 16'($urandom));
        2: ins = enc_r(rd, rs, rt, fl[$urandom_range(0, 5)]);
        3: ins = enc_r(rd, rs, rt, 6'($urandom_range(0, 63)));
        4: ins = enc_i(6'h2B, rd, rs, 16'($urandom));
        default: ins = enc_i(6'h11, rd, rs, 16'($urandom));
      endcase
      issue(ins);
      other = $urandom_range(0, 7);
      checks++; if (get_reg(rd) !== m_reg[rd])
        $display("FAIL rand%0d_rd got %08h want %08h", n, get_reg(rd), m_reg[rd]); else passed++;
      checks++; if (get_reg(other) !== m_reg[other])
        $display("FAIL rand%0d_r%0d got %08h want %08h", n, other, get_reg(other), m_reg[other]); else passed++;
      checks++; if (out !== m_out) $display("FAIL rand%0d_out got %08h want %08h", n, out, m_out); else passed++;
      checks++; if (addr !== m_pc || rw !== 1'b0)
        $display("FAIL rand%0d_bus got addr=%08h rw=%0d want %08h/0", n, addr, rw, m_pc); else passed++;
    end
  endtask

  task automatic test_halt();
    issue(32'hFC000000);
    checks++; if (sys_dne !== 1'b1) $display("FAIL halt_dne got %0d want 1", sys_dne); else passed++;
    checks++; if (int'(i1.c.state) != 2) $display("FAIL halt_state got %0d want 2", i1.c.state); else passed++;
    issue(enc_i(6'h0A, 5, 0, 16'h7777));
    issue(enc_r(5, 1, 2, 6'h20));
    checks++; if (i1.r5.internal !== m_reg[5])
      $display("FAIL halt_r5 got %08h want %08h", i1.r5.internal, m_reg[5]); else passed++;
    checks++; if (addr !== m_pc || out !== m_out)
      $display("FAIL halt_frozen got addr=%08h out=%08h want %08h/%08h", addr, out, m_pc, m_out); else passed++;
    do_reset();
    checks++; if (sys_dne !== 1'b0) $display("FAIL halt_rst_dne got %0d want 0", sys_dne); else passed++;
    checks++; if (addr !== 32'd0) $display("FAIL halt_rst_addr got %08h want 0", addr); else passed++;
    checks++; if (int'(i1.c.state) != 0) $display("FAIL halt_rst_state got %0d want 0", i1.c.state); else passed++;
  endtask

  task automatic test_reset_exec();
    issue(32'h29201234);
    checks++; if (i1.r9.internal !== 32'h00001234)
      $display("FAIL rx_pre_r9 got %08h want 00001234", i1.r9.internal); else passed++;
    instruction = 32'h29205678;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    $display("instr %08h : reset in EXEC addr=%08h", instruction, addr);
    checks++; if (i1.r9.internal !== 32'h00001234)
      $display("FAIL rx_r9 got %08h want 00001234", i1.r9.internal); else passed++;
    checks++; if (addr !== 32'd0) $display("FAIL rx_addr got %08h want 0", addr); else passed++;
    checks++; if (int'(i1.c.state) != 0) $display("FAIL rx_state got %0d want 0", i1.c.state); else passed++;
  endtask

  initial begin
    reset = 1'b0;
    instruction = 32'd0;
    for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
    m_pc = 0; m_out = 0; m_halt = 0;
    test_reset();
    test_li_basic();
    test_li_sequence();
    test_rtype();
    test_store();
    test_random();
    test_halt();
    test_reset_exec();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 The module SHALL have one clock, clk; reset is synchronous and active-low, on port reset (0 = reset, sampled on the rising edge of clk).
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous active-low reset.
REQ-004 Port instruction  input  32  instruction word, sampled in FETCH.
REQ-005 Port addr  output  32  registered program counter (byte address of the current instruction).
REQ-006 Port out  output  32  registered data output.
REQ-007 Port rw  output  1  registered bus direction: 0 = read/fetch, 1 = write (store).
REQ-008 Port sys_dne  output  1  registered halt flag.
REQ-009 Internal visibility: register instances r0..r31 each hold 32-bit storage named internal; controller instance c holds state. Bench probes i1.rN.internal and i1.c.state.

Function
REQ-010 Instruction fields: opcode [31:26], rd [25:21], rs [20:16], rt [15:11], imm [15:0], funct [5:0].
REQ-011 Register file: 32 x 32-bit; two combinational reads (rs/rd, rt); one synchronous write, only in EXEC; r0 behaves as an ordinary register.
REQ-012 Controller states: FETCH=0, EXEC=1, HALT=2. FETCH->EXEC always; EXEC->FETCH, or EXEC->HALT for HALT opcode; HALT stays HALT until reset.
REQ-013 FETCH: latch instruction into internal IR on the rising edge; no architectural change.
REQ-014 EXEC: perform the decoded operation from IR; on the same edge, addr <= addr + 4 (32-bit wrap-around).
REQ-015 Each instruction takes exactly 2 cycles; its result is visible after the second rising edge following its presentation in FETCH.
REQ-016 Opcode 0x0A LI: R[rd] <= sign-extended imm; out <= same value (e.g. 0x2B40FA37 -> r26 = FFFFFA37).
REQ-017 Opcode 0x00 R-type, R[rd] <= R[rs] op R[rt]; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A signed slt (1/0); out <= result; 32-bit modular arithmetic, no overflow flag; other funct = NOP.
REQ-018 Opcode 0x0C ADDI: R[rd] <= R[rs] + sign-extended imm; out <= result.
REQ-019 Opcode 0x2B ST: during EXEC, rw = 1, out = R[rd], bus address = R[rs] + sext(imm) presented on addr for that cycle only; the PC update completes on the EXEC edge; no register write.
REQ-020 Opcode 0x3F HALT: sys_dne <= 1, enter HALT; addr, out and registers are frozen.
REQ-021 Any other opcode: NOP (PC advances, no register write, out unchanged).
REQ-022 rw = 0 in all cycles except ST EXEC.
REQ-023 Registers not written by an instruction SHALL keep their value across instructions (no spurious writes in FETCH).

Reset
REQ-024 With reset = 0 at a rising edge: state <= FETCH, IR <= 0, addr <= 0, out <= 0, rw <= 0, sys_dne <= 0.
REQ-025 Reset does not clear the register file; never-written registers read X in simulation.
REQ-026 Reset asserted during EXEC suppresses that edge's write-back, store and PC update; reset has priority over all other events, including HALT.
REQ-027 After reset deasserts, the first rising edge is a FETCH.

Verification
REQ-028 Reset 1 cycle, then LI 0x2B40FA37 -> after 2 edges r26 = FFFFFA37; r27, r28, r29 remain X; addr = 4.
REQ-029 LI sequence 0x2BA0600B, 0x2B800035, 0x2B600183, 2 cycles each -> r29 = 0000600B, r28 = 00000035, r27 = 00000183; r26 keeps FFFFFA37; c.state = 0 after each instruction.
REQ-030 LI r1 = 5, LI r2 = FFFFFFFD, R-type add/sub/slt into r3 -> r3 = 00000002, 00000008, 00000000 respectively; out matches each result.
REQ-031 ST rd=r1, rs=r2, imm=4 -> in EXEC: rw = 1, out = R[r1], addr = R[r2] + 4; next cycle rw = 0.
REQ-032 HALT 0xFC000000 -> sys_dne = 1 and c.state = 2 after 2 edges; further instructions cause no change; reset then clears sys_dne, addr = 0, c.state = 0.
REQ-033 Reset asserted during EXEC of an LI -> target register unchanged, addr = 0.
